// File: rtl/tlin_wave_line.sv
// Lossy transmission-line model: forward (a->b) and backward (b->a) waves,
// each delayed by a programmable sample count and attenuated by an arithmetic shift.
module tlin_wave_line #(
    parameter int W     = 16,
    parameter int DEPTH = 64,
    parameter int DLY_W = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_load,
    input  logic [DLY_W-1:0]    cfg_delay,
    input  logic [3:0]          cfg_atten,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] a_in,
    input  logic signed [W-1:0] b_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] b_out,
    output logic signed [W-1:0] a_out,
    output logic                filling
);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DLY_W-1:0]    delay_q, delay_d;
    logic [3:0]          atten_q, atten_d;
    logic [DLY_W-1:0]    wptr_q, wptr_d;
    logic [DLY_W-1:0]    fill_q, fill_d;
    logic                out_valid_q, out_valid_d;
    logic signed [W-1:0] b_out_q, b_out_d;
    logic signed [W-1:0] a_out_q, a_out_d;

    logic signed [W-1:0] mem_fwd [DEPTH];
    logic signed [W-1:0] mem_bwd [DEPTH];

    logic                accept;
    logic [DLY_W-1:0]    rd_addr;
    logic [DLY_W-1:0]    delay_m1;
    logic signed [W-1:0] src_fwd, src_bwd;

    assign in_ready  = !cfg_load && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign rd_addr   = wptr_q - delay_q;
    assign delay_m1  = delay_q - DLY_W'(1);
    assign out_valid = out_valid_q;
    assign b_out     = b_out_q;
    assign a_out     = a_out_q;
    assign filling   = (state_q == FILL);

    // Zero delay bypasses the RAM; otherwise the read precedes this cycle's write.
    always_comb begin
        src_fwd = (delay_q == '0) ? a_in : mem_fwd[rd_addr];
        src_bwd = (delay_q == '0) ? b_in : mem_bwd[rd_addr];
    end

    always_comb begin
        state_d     = state_q;
        delay_d     = delay_q;
        atten_d     = atten_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        out_valid_d = out_valid_q;
        b_out_d     = b_out_q;
        a_out_d     = a_out_q;

        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (cfg_load) begin
            delay_d = cfg_delay;
            atten_d = cfg_atten;
            wptr_d  = '0;
            fill_d  = '0;
            state_d = FILL;
        end else if (accept) begin
            wptr_d = wptr_q + DLY_W'(1);
            if (state_q == RUN || delay_q == '0) begin
                b_out_d = src_fwd >>> atten_q;
                a_out_d = src_bwd >>> atten_q;
            end else begin
                b_out_d = '0;
                a_out_d = '0;
            end
            if (state_q == FILL) begin
                fill_d = fill_q + DLY_W'(1);
                if (delay_q == '0 || fill_q == delay_m1) begin
                    state_d = RUN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= FILL;
            delay_q     <= '0;
            atten_q     <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            out_valid_q <= 1'b0;
            b_out_q     <= '0;
            a_out_q     <= '0;
        end else begin
            state_q     <= state_d;
            delay_q     <= delay_d;
            atten_q     <= atten_d;
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            out_valid_q <= out_valid_d;
            b_out_q     <= b_out_d;
            a_out_q     <= a_out_d;
        end
    end

    // Buffer contents are never cleared; FILL masking hides stale entries.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_fwd[wptr_q] <= a_in;
            mem_bwd[wptr_q] <= b_in;
        end
    end

endmodule

// File: doc/tlin_wave_line.md
Name: tlin_wave_line

Overview:
- Sampled-data digital model of a lossy transmission line (TLIN), driven by the mixed-signal co-simulation sample stream.
- Carries two travelling waves: forward, entering port a and leaving port b; backward, entering port b and leaving port a.
- Each wave is delayed by a programmable number of samples and attenuated by a programmable power-of-two factor.
- Sits between the sample-stream producer (analog-to-digital bridge) and consumer; valid/ready handshake on both sides.

Parameters:
- W, 16, signed sample width of every wave port.
- DEPTH, 64, delay buffer entries per direction; power of two; maximum usable delay is DEPTH-1.
- DLY_W, 6, width of the delay configuration; equals log2(DEPTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- cfg_load  in  1  one-cycle strobe; latches cfg_delay and cfg_atten.
- cfg_delay  in  DLY_W  line delay in samples.
- cfg_atten  in  4  attenuation as an arithmetic right-shift count.
- in_valid  in  1  a_in/b_in pair is valid.
- in_ready  out  1  block accepts the input pair this cycle.
- a_in  in  W  signed incident wave at port a.
- b_in  in  W  signed incident wave at port b.
- out_valid  out  1  b_out/a_out pair is valid.
- out_ready  in  1  consumer accepts the output pair.
- b_out  out  W  signed forward wave leaving port b.
- a_out  out  W  signed backward wave leaving port a.
- filling  out  1  high while the line is still in FILL.

Behaviour:
- Reset (rst_n=0 at an edge), regardless of any in-flight transfer:
  - out_valid=0, b_out=0, a_out=0.
  - delay register=0, atten register=0.
  - write pointer=0, fill counter=0, state=FILL.
  - Buffer RAM contents are not cleared; FILL masking makes stale contents unobservable.
- Configuration:
  - cfg_load=1 latches cfg_delay and cfg_atten.
  - Clears the write pointer and fill counter and forces state FILL.
  - in_ready is 0 in any cycle where cfg_load=1; cfg_load therefore has priority and no sample is accepted that cycle.
  - A pending output is not flushed; it keeps out_valid until it is consumed.
- Handshake:
  - in_ready = !cfg_load && (!out_valid || out_ready). This is a one-deep registered output stage.
  - Accept = in_valid && in_ready.
  - Each accept produces exactly one output pair, registered on the same edge, so latency is 1 cycle.
  - out_valid rises on the accept edge. It falls on an edge with out_valid && out_ready && no new accept.
  - b_out/a_out are held stable while out_valid && !out_ready.
- Delay semantics, with k = accept index since the last reset or cfg_load (starting at 0) and d = latched delay:
  - b_out(k) = a_in(k-d) >>> atten; a_out(k) = b_in(k-d) >>> atten.
  - For k < d the output value is 0.
  - d=0: the input bypasses the RAM, so b_out = a_in >>> atten at 1-cycle latency.
- Buffer:
  - Two DEPTH x W RAMs share one write pointer, which increments on every accept and wraps from DEPTH-1 to 0.
  - Read address = (wptr - d) mod DEPTH. The read happens before the write in the same cycle, so there is no read-during-write hazard for d>=1.
- State machine:
  - FILL: outputs are forced to 0; the fill counter increments on each accept. Move to RUN on the accept where counter == d-1; with d=0, RUN is entered directly.
  - RUN: outputs come from the buffer read. Leave RUN only on cfg_load or reset.
  - filling = (state==FILL).
- Arithmetic:
  - >>> is an arithmetic shift, rounding toward -infinity (e.g. -3 >>> 1 = -2).
  - atten >= W gives 0 for non-negative inputs and -1 for negative inputs.
  - No saturation is needed.

Test Plan:
- Reset, then cfg d=0, atten=0; push a_in=100, b_in=-7 -> next cycle out_valid=1, b_out=100, a_out=-7.
- cfg d=3, atten=1; push a_in sequence 10,20,30,40,50 -> b_out sequence 0,0,0,5,10; filling high for the first 3 outputs only.
- cfg d=63; push 130 ramp samples a_in=k -> b_out(k)=0 for k<63, then k-63; checks pointer wrap-around at 64.
- d=2, out_ready held low for 4 cycles with in_valid high -> in_ready=0, outputs frozen, no sample lost; resume shows a contiguous delayed sequence.
- cfg_load asserted in the same cycle as in_valid -> that sample is not accepted (in_ready=0); the next outputs restart from zero fill.
- rst_n low mid-stream for 1 cycle -> out_valid=0, outputs=0, filling=1; a pushed sample then passes with d=0 (1-cycle latency).
